multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry.
REQ-003 Parameter MEM_TIMEOUT, 16 (range 0..65535), wait cycles before a memory timeout trap; 0 disables timeout.
REQ-004 Parameter STORE_ACK, 0; 1 = stores wait for dataReady, 0 = stores retire after a fixed one-cycle delay.
REQ-005 Parameter ENABLE_IRQ, 1; 0 ties interrupt acceptance off.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 opcode  in  7  current instruction opcode from decoder.
REQ-009 pcAddr  in  32  branch/jump target.
REQ-010 pcWrEn  in  1  take pcAddr at writeback.
REQ-011 memReady  in  1  memory accepts a request.
REQ-012 dataReady  in  1  memory completed the request.
REQ-013 irq  in  1  level interrupt request.
REQ-014 memExecute  out  1  registered one-cycle request strobe.
REQ-015 outState  out  4  current main state code.
REQ-016 outputPC  out  32  current PC.
REQ-017 trapTaken  out  1  one-cycle pulse on trap entry.
REQ-018 trapCause  out  4  cause of last trap, held until next trap.
REQ-019 trapEpc  out  32  PC saved at last trap, held until next trap.

Function
REQ-020 Main states/codes: FETCH 0, DECODE 1, EXECUTE 2, MEM 3, WB 4, RETIRE 5, TRAP 6; other codes go to FETCH next cycle, PC unchanged.
REQ-021 Memory sub-FSM used in FETCH and MEM: IDLE -> (memReady) REQ -> WAIT -> (completion) IDLE; memExecute high exactly during the REQ cycle.
REQ-022 FETCH/IDLE with outputPC[1:0] != 0: no request issued; go to TRAP, cause 0, epc = outputPC.
REQ-023 FETCH/WAIT with dataReady: -> DECODE; DECODE -> EXECUTE unconditionally.
REQ-024 EXECUTE: opcode 7'b0000011 (load) or 7'b0100011 (store) -> MEM; else -> WB.
REQ-025 MEM/WAIT load: dataReady -> WB.
REQ-026 MEM/WAIT store: STORE_ACK=1 waits dataReady; STORE_ACK=0 leaves after exactly one WAIT cycle; either way -> WB.
REQ-027 WB: PC <= pcAddr if pcWrEn else PC + 4 (32-bit wrap, 32'hFFFF_FFFC + 4 = 0); -> RETIRE.
REQ-028 RETIRE: if ENABLE_IRQ and irq=1 -> TRAP, cause 11, epc = outputPC (already next PC); else -> FETCH.
REQ-029 Timeout counter: cleared on entering WAIT, increments each WAIT cycle without completion; reaching MEM_TIMEOUT -> TRAP, cause 1 (fetch) or 5 (load/store).
REQ-030 Completion and timeout in same cycle: completion wins.
REQ-031 STORE_ACK=0 stores never time out.
REQ-032 TRAP (one cycle): PC <= TRAP_VECTOR, trapTaken=1, trapCause/trapEpc update, sub-FSM to IDLE; -> FETCH.
REQ-033 irq sampled only in RETIRE; irq deasserted before RETIRE is ignored.
REQ-034 Trap at TRAP_VECTOR with misaligned TRAP_VECTOR loops cause-0 traps; legal, not guarded.

Reset
REQ-035 reset=0 at a rising edge: state FETCH, sub-FSM IDLE, PC=RESET_VECTOR, memExecute=0, trapTaken=0, trapCause=0, trapEpc=0, counter=0.
REQ-036 Reset mid-transaction (REQ or WAIT) abandons it; memExecute low the cycle after reset sampled; late dataReady ignored since sub-FSM is IDLE.

Structure
REQ-037 Shared package holds main-state codes, sub-state codes, trap-cause constants, and LOAD/STORE opcode constants.
REQ-038 One sub-module mem_handshake implements the sub-FSM and timeout counter (inputs start, isStore; outputs done, timeout); reused for FETCH and MEM.

Verification
REQ-039 Reset release, memReady=1, dataReady 3 cycles after strobe, ALU opcode 7'b0110011 -> one-cycle memExecute, states 0,1,2,4,5,0, PC 0 -> 4.
REQ-040 Load with pcWrEn=0, dataReady 2 cycles late -> passes state 3, PC +4; STORE_ACK=0 store, dataReady never -> WB one cycle after WAIT entry, no trap.
REQ-041 MEM_TIMEOUT=4, fetch dataReady never -> TRAP after 4 WAIT cycles, trapCause=1, trapEpc=old PC, PC=32'h100, trapTaken one cycle.
REQ-042 JAL-style pcWrEn=1, pcAddr=32'h0000_0102 -> next FETCH traps cause 0 without memExecute, trapEpc=32'h102.
REQ-043 irq=1 during RETIRE after PC 0 -> 4 -> TRAP cause 11, trapEpc=4, PC=32'h100; irq pulse in DECODE only -> no trap.
REQ-044 reset=0 in WAIT, dataReady next cycle -> state 0, PC=RESET_VECTOR, no advance to DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: main/sub state codes, trap causes and
// the memory opcodes that divert EXECUTE into the MEM phase.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StRetire  = 3'd5,
        StTrap    = 3'd6
    } main_state_e;

    typedef enum logic [1:0] {
        SubIdle = 2'd0,
        SubReq  = 2'd1,
        SubWait = 2'd2
    } sub_state_e;

    localparam logic [3:0] CauseMisaligned   = 4'd0;
    localparam logic [3:0] CauseFetchTimeout = 4'd1;
    localparam logic [3:0] CauseMemTimeout   = 4'd5;
    localparam logic [3:0] CauseIrq          = 4'd11;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder/memory/trap signal bundle of the multicycle controller.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic [31:0] pcAddr;
    logic        pcWrEn;
    logic        memReady;
    logic        dataReady;
    logic        irq;
    logic        memExecute;
    logic [3:0]  outState;
    logic [31:0] outputPC;
    logic        trapTaken;
    logic [3:0]  trapCause;
    logic [31:0] trapEpc;

    modport master (
        input  opcode, pcAddr, pcWrEn, memReady, dataReady, irq,
        output memExecute, outState, outputPC, trapTaken, trapCause, trapEpc
    );

    modport slave (
        output opcode, pcAddr, pcWrEn, memReady, dataReady, irq,
        input  memExecute, outState, outputPC, trapTaken, trapCause, trapEpc
    );
endinterface

// File: rtl/mem_handshake.sv
// Memory request sub-FSM (IDLE -> REQ -> WAIT) with wait-cycle timeout, shared by the
// fetch and load/store phases.
module mem_handshake
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          STORE_ACK   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isStore,
    input  logic abort,
    input  logic memReady,
    input  logic dataReady,
    output logic memExecute,
    output logic done,
    output logic timeout
);

    localparam logic [16:0] Limit = 17'(MEM_TIMEOUT);

    sub_state_e  sub_q, sub_d;
    logic [15:0] cnt_q, cnt_d;
    logic        exec_q;
    logic        complete;

    always_comb begin
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        timeout = 1'b0;
        // Unacknowledged stores complete on their first WAIT cycle, so they cannot time out.
        complete = (isStore && !STORE_ACK) ? 1'b1 : dataReady;
        unique case (sub_q)
            SubIdle: if (start && memReady) sub_d = SubReq;
            SubReq: begin
                sub_d = SubWait;
                cnt_d = '0;
            end
            SubWait: begin
                if (complete) begin
                    done  = 1'b1;
                    sub_d = SubIdle;
                end else if (Limit != 17'd0 && ({1'b0, cnt_q} + 17'd1) == Limit) begin
                    timeout = 1'b1;
                    sub_d   = SubIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: sub_d = SubIdle;
        endcase
        if (abort) sub_d = SubIdle;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sub_q  <= SubIdle;
            cnt_q  <= '0;
            exec_q <= 1'b0;
        end else begin
            sub_q  <= sub_d;
            cnt_q  <= cnt_d;
            exec_q <= (sub_d == SubReq);
        end
    end

    assign memExecute = exec_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback/retire sequencing with
// misalignment, memory-timeout and interrupt traps.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          STORE_ACK    = 1'b0,
    parameter bit          ENABLE_IRQ   = 1'b1
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);

    main_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic        in_fetch, in_mem, misaligned;
    logic        hs_start, hs_store, hs_abort, hs_done, hs_timeout, hs_exec;

    assign in_fetch   = (state_q == StFetch);
    assign in_mem     = (state_q == StMem);
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign hs_start   = (in_fetch && !misaligned) || in_mem;
    assign hs_store   = in_mem && (bus.opcode == OpStore);
    assign hs_abort   = !(in_fetch || in_mem);

    mem_handshake #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .STORE_ACK  (STORE_ACK)
    ) u_mem_handshake (
        .clk       (clk),
        .reset     (reset),
        .start     (hs_start),
        .isStore   (hs_store),
        .abort     (hs_abort),
        .memReady  (bus.memReady),
        .dataReady (bus.dataReady),
        .memExecute(hs_exec),
        .done      (hs_done),
        .timeout   (hs_timeout)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        unique case (state_q)
            StFetch: begin
                if (misaligned) begin
                    state_d = StTrap;
                    cause_d = CauseMisaligned;
                    epc_d   = pc_q;
                end else if (hs_done) begin
                    state_d = StDecode;
                end else if (hs_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseFetchTimeout;
                    epc_d   = pc_q;
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: begin
                state_d = (bus.opcode == OpLoad || bus.opcode == OpStore) ? StMem : StWb;
            end
            StMem: begin
                if (hs_done) begin
                    state_d = StWb;
                end else if (hs_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseMemTimeout;
                    epc_d   = pc_q;
                end
            end
            StWb: begin
                pc_d    = bus.pcWrEn ? bus.pcAddr : pc_q + 32'd4;
                state_d = StRetire;
            end
            StRetire: begin
                // pc_q already holds the next PC here, so that is what gets saved.
                if (ENABLE_IRQ && bus.irq) begin
                    state_d = StTrap;
                    cause_d = CauseIrq;
                    epc_d   = pc_q;
                end else begin
                    state_d = StFetch;
                end
            end
            StTrap: begin
                pc_d    = TRAP_VECTOR;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_VECTOR;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.memExecute = hs_exec;
    assign bus.outState   = {1'b0, state_q};
    assign bus.outputPC   = pc_q;
    assign bus.trapTaken  = (state_q == StTrap);
    assign bus.trapCause  = cause_q;
    assign bus.trapEpc    = epc_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench: an instruction-level model expands each directed instruction into its expected
// cycle trace, and one compare process checks the controller on every planned cycle.
module tb_multicycle_ctrl;

    localparam logic [31:0] ResetVec   = 32'h0000_0000;
    localparam logic [31:0] TrapVec    = 32'h0000_0100;
    localparam int          MemTimeout = 4;

    localparam logic [3:0] SF = 4'd0, SD = 4'd1, SE = 4'd2, SM = 4'd3;
    localparam logic [3:0] SW = 4'd4, SR = 4'd5, ST = 4'd6;

    localparam logic [6:0] OpAlu   = 7'b0110011;
    localparam logic [6:0] OpLd    = 7'b0000011;
    localparam logic [6:0] OpSt    = 7'b0100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef struct {
        logic        rst_n;
        logic [6:0]  opcode;
        logic [31:0] pc_addr;
        logic        pc_wr, mem_rdy, data_rdy, irq;
        bit          chk;
        logic [3:0]  st;
        logic [31:0] pc;
        logic        mexec, ttaken;
        logic [3:0]  cause;
        logic [31:0] epc;
        bit          pin;
        logic [3:0]  pin_st;
        logic [31:0] pin_pc;
        logic [3:0]  pin_cause;
        logic [31:0] pin_epc;
    } cyc_t;

    logic clk;
    logic reset;
    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .RESET_VECTOR(ResetVec),
        .TRAP_VECTOR (TrapVec),
        .MEM_TIMEOUT (MemTimeout),
        .STORE_ACK   (1'b0),
        .ENABLE_IRQ  (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cyc_t        plan[$];
    cyc_t        cur;
    bit          cur_valid = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    // Architectural model state and per-instruction stimulus.
    logic [31:0] m_pc, m_epc;
    logic [3:0]  m_cause;
    logic [6:0]  s_op;
    logic [31:0] s_addr;
    logic        s_wr;
    bit          s_rst = 1'b1;
    bit          s_chk = 1'b1;

    task automatic push(input logic [3:0] st, input logic mexec, input logic mrdy,
                        input logic drdy, input logic irq_v);
        cyc_t c;
        c.rst_n = s_rst;   c.opcode = s_op;  c.pc_addr = s_addr; c.pc_wr = s_wr;
        c.mem_rdy = mrdy;  c.data_rdy = drdy; c.irq = irq_v;
        c.chk = s_chk;     c.st = st;        c.pc = m_pc;       c.mexec = mexec;
        c.ttaken = (st == ST);
        c.cause = m_cause; c.epc = m_epc;
        c.pin = 1'b0;      c.pin_st = '0;    c.pin_pc = '0;     c.pin_cause = '0;
        c.pin_epc = '0;
        plan.push_back(c);
    endtask

    task automatic pin(input logic [3:0] st, input logic [31:0] pc, input logic [3:0] cause,
                       input logic [31:0] epc);
        cyc_t c;
        c = plan.pop_back();
        c.pin = 1'b1; c.pin_st = st; c.pin_pc = pc; c.pin_cause = cause; c.pin_epc = epc;
        plan.push_back(c);
    endtask

    task automatic do_reset();
        s_rst = 1'b0; s_chk = 1'b0;
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b1; s_chk = 1'b1;
        m_pc = ResetVec; m_cause = 4'd0; m_epc = 32'd0;
    endtask

    task automatic take_trap(input logic [3:0] cause, input logic [31:0] epc);
        m_cause = cause;
        m_epc   = epc;
        push(ST, 1'b0, 1'b0, 1'b0, 1'b0);
        m_pc = TrapVec;
    endtask

    // wait_n: WAIT cycle (1-based) carrying dataReady; 0 means memory never answers.
    task automatic mem_access(input int wait_n, input bit store, input logic [3:0] st,
                              output bit ok);
        bit drdy;
        ok = 1'b0;
        push(st, 1'b0, 1'b1, 1'b0, 1'b0);
        push(st, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= MemTimeout; k++) begin
            drdy = (k == wait_n);
            push(st, 1'b0, 1'b0, drdy, 1'b0);
            if (store || drdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic instr(input logic [6:0] op, input int fwait, input int mwait,
                         input logic wr, input logic [31:0] addr, input bit irq_dec,
                         input bit irq_ret);
        bit ok;
        s_op = op; s_addr = addr; s_wr = wr;
        if (m_pc[1:0] != 2'b00) begin
            push(SF, 1'b0, 1'b1, 1'b0, 1'b0);
            take_trap(4'd0, m_pc);
        end else begin
            mem_access(fwait, 1'b0, SF, ok);
            if (!ok) begin
                take_trap(4'd1, m_pc);
            end else begin
                push(SD, 1'b0, 1'b0, 1'b0, irq_dec);
                push(SE, 1'b0, 1'b0, 1'b0, 1'b0);
                if (op == OpLd || op == OpSt) mem_access(mwait, op == OpSt, SM, ok);
                if (!ok) begin
                    take_trap(4'd5, m_pc);
                end else begin
                    push(SW, 1'b0, 1'b0, 1'b0, 1'b0);
                    m_pc = wr ? addr : m_pc + 32'd4;
                    push(SR, 1'b0, 1'b0, 1'b0, irq_ret);
                    if (irq_ret) take_trap(4'd11, m_pc);
                end
            end
        end
    endtask

    task automatic build_plan();
        s_op = OpAlu; s_addr = '0; s_wr = 1'b0;
        m_pc = ResetVec; m_cause = '0; m_epc = '0;
        do_reset();
        do_reset();
        instr(OpAlu, 3, 0, 1'b0, 32'h0, 1'b0, 1'b0);          // PC 0 -> 4
        pin(SR, 32'h4, 4'd0, 32'h0);
        instr(OpLd, 1, 2, 1'b0, 32'h0, 1'b0, 1'b0);           // load, data 2 cycles late
        instr(OpSt, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);           // unacked store, no data
        instr(OpAlu, 1, 0, 1'b0, 32'h0, 1'b1, 1'b0);          // irq only in DECODE
        instr(OpJal, 1, 0, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
        instr(OpAlu, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);          // misaligned fetch trap
        pin(ST, 32'h102, 4'd0, 32'h102);
        instr(OpAlu, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);          // fetch timeout
        pin(ST, 32'h100, 4'd1, 32'h100);
        // Reset during fetch WAIT, memory answers one cycle later.
        s_op = OpAlu;
        push(SF, 1'b0, 1'b1, 1'b0, 1'b0);
        push(SF, 1'b1, 1'b0, 1'b0, 1'b0);
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b0;
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b1;
        m_pc = ResetVec; m_cause = '0; m_epc = '0;
        push(SF, 1'b0, 1'b0, 1'b1, 1'b0);
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
        pin(SF, 32'h0, 4'd0, 32'h0);
        instr(OpAlu, 2, 0, 1'b0, 32'h0, 1'b0, 1'b1);          // irq at RETIRE
        pin(ST, 32'h4, 4'd11, 32'h4);
        instr(OpLd, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);           // load timeout
        pin(ST, 32'h100, 4'd5, 32'h100);
        instr(OpAlu, 1, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        instr(OpAlu, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);          // PC wraps to 0
        pin(SR, 32'h0, 4'd5, 32'h100);
        instr(OpAlu, MemTimeout, 0, 1'b0, 32'h0, 1'b0, 1'b0); // completion beats timeout
        pin(SR, 32'h4, 4'd5, 32'h100);
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
        push(SF, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cur_valid && cur.chk) begin
            n_total++;
            if ({bus.outState, bus.outputPC, bus.memExecute, bus.trapTaken, bus.trapCause,
                 bus.trapEpc} === {cur.st, cur.pc, cur.mexec, cur.ttaken, cur.cause, cur.epc})
                n_pass++;
            else
                $display("FAIL cycle @%0t: got st=%0d pc=%h mx=%b tt=%b cause=%0d epc=%h, want st=%0d pc=%h mx=%b tt=%b cause=%0d epc=%h",
                         $time, bus.outState, bus.outputPC, bus.memExecute, bus.trapTaken,
                         bus.trapCause, bus.trapEpc, cur.st, cur.pc, cur.mexec, cur.ttaken,
                         cur.cause, cur.epc);
        end
        if (cur_valid && cur.pin) begin
            n_total++;
            if ({bus.outState, bus.outputPC, bus.trapCause, bus.trapEpc} ===
                {cur.pin_st, cur.pin_pc, cur.pin_cause, cur.pin_epc})
                n_pass++;
            else
                $display("FAIL pin @%0t: got st=%0d pc=%h cause=%0d epc=%h, want st=%0d pc=%h cause=%0d epc=%h",
                         $time, bus.outState, bus.outputPC, bus.trapCause, bus.trapEpc,
                         cur.pin_st, cur.pin_pc, cur.pin_cause, cur.pin_epc);
        end
    end

    initial begin
        reset         = 1'b0;
        bus.opcode    = '0;
        bus.pcAddr    = '0;
        bus.pcWrEn    = 1'b0;
        bus.memReady  = 1'b0;
        bus.dataReady = 1'b0;
        bus.irq       = 1'b0;
        build_plan();
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk);
            #1;
            cur           = plan[i];
            reset         = cur.rst_n;
            bus.opcode    = cur.opcode;
            bus.pcAddr    = cur.pc_addr;
            bus.pcWrEn    = cur.pc_wr;
            bus.memReady  = cur.mem_rdy;
            bus.dataReady = cur.data_rdy;
            bus.irq       = cur.irq;
            cur_valid     = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
